blast_word_window: RTL and testbench

Upstream stage of the 11-way seed AND gate in the BLAST seed-match path. It accepts a database nucleotide stream over a valid/ready handshake and keeps a sliding window of the last `W` nucleotides. Each cycle it compares the window position-by-position against a latched query word. It emits `W` per-position equality bits (`m_eq[0..W-1]`, which drive AND inputs `a0..a10`) together with the window's start position in the database sequence.

---
 rtl/blast_word_window_if.sv | 28 ++
 rtl/blast_word_window.sv | 97 +++++++++
 tb/tb_blast_word_window.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/blast_word_window_if.sv
// Port bundle for the BLAST word window: query load, database stream in,
// per-position match vector out.
interface blast_word_window_if #(
  parameter int W     = 11,
  parameter int POS_W = 32
);
  logic             q_load;
  logic [2*W-1:0]   q_word;
  logic             db_valid;
  logic [1:0]       db_nt;
  logic             db_last;
  logic             db_ready;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_eq;
  logic [POS_W-1:0] m_pos;
  logic             m_last;

  modport master (
    output q_load, q_word, db_valid, db_nt, db_last, m_ready,
    input  db_ready, m_valid, m_eq, m_pos, m_last
  );

  modport slave (
    input  q_load, q_word, db_valid, db_nt, db_last, m_ready,
    output db_ready, m_valid, m_eq, m_pos, m_last
  );
endinterface

// File: rtl/blast_word_window.sv
// Sliding W-nucleotide window over the database stream, compared lane-by-lane
// against a latched query word; feeds the 11-input seed AND gate.
module blast_nt_cmp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

module blast_word_window #(
  parameter int W     = 11,
  parameter int POS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  blast_word_window_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  typedef struct packed {
    logic [W-1:0]     eq;
    logic [POS_W-1:0] pos;
    logic             last;
  } mout_t;

  localparam logic [POS_W-1:0] LAST_FILL = POS_W'(W - 1);

  state_t                 state, state_nxt;
  logic [W-1:0][1:0]      win, win_nxt, qry;
  logic [POS_W-1:0]       cnt;
  logic [W-1:0]           eq_nxt;
  mout_t                  mout;
  logic                   m_valid, ready, acc, emit;

  assign ready   = (state != IDLE) && !bus.q_load && (!m_valid || bus.m_ready);
  assign acc     = bus.db_valid && ready;
  // Newest nucleotide enters at lane W-1; lane 0 is the oldest.
  assign win_nxt = {bus.db_nt, win[W-1:1]};
  // Once in RUN the count may wrap, but every accept still produces a window.
  assign emit    = acc && ((state == RUN) || (cnt == LAST_FILL));

  for (genvar i = 0; i < W; i++) begin : g_lane
    blast_nt_cmp u_cmp (.a(win_nxt[i]), .b(qry[i]), .eq(eq_nxt[i]));
  end

  always_comb begin
    state_nxt = state;
    if (bus.q_load)
      state_nxt = FILL;
    else if (acc) begin
      if (bus.db_last)
        state_nxt = FILL;
      else if ((state == FILL) && (cnt == LAST_FILL))
        state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qry     <= '0;
      win     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      mout    <= '0;
    end else if (bus.q_load) begin
      qry     <= bus.q_word;
      win     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else begin
      if (acc) begin
        win <= bus.db_last ? '0 : win_nxt;
        cnt <= bus.db_last ? '0 : cnt + 1'b1;
      end
      if (emit) begin
        mout.eq   <= eq_nxt;
        mout.pos  <= cnt - LAST_FILL;
        mout.last <= bus.db_last;
        m_valid   <= 1'b1;
      end else if (bus.m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign bus.db_ready = ready;
  assign bus.m_valid  = m_valid;
  assign bus.m_eq     = mout.eq;
  assign bus.m_pos    = mout.pos;
  assign bus.m_last   = mout.last;
endmodule

// File: tb/tb_blast_word_window.sv
// Directed bench for blast_word_window: queue-based reference model checked
// every cycle, plus literal expectations on the delivered-window log.
module tb_blast_word_window;
  localparam int W     = 11;
  localparam int POS_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blast_word_window_if #(.W(W), .POS_W(POS_W)) bus ();
  blast_word_window #(.W(W), .POS_W(POS_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: the current sequence's last W nucleotides as a queue.
  bit               loaded;
  int unsigned      hist[$];
  longint           k;
  logic [2*W-1:0]   mq;
  bit               e_valid;
  logic [W-1:0]     e_eq;
  logic [POS_W-1:0] e_pos;
  bit               e_last;

  typedef struct {
    int unsigned pos;
    int unsigned eq;
    bit          last;
    int          cyc;
  } rec_t;
  rec_t log_q[$];

  wire exp_ready = loaded && !bus.q_load && (!e_valid || bus.m_ready);

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] code(byte c);
    case (c)
      "A": return 2'd0;
      "C": return 2'd1;
      "G": return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      loaded = 0; hist.delete(); k = 0; mq = '0;
      e_valid = 0; e_eq = '0; e_pos = '0; e_last = 0;
    end else begin
      bit hs, acc;
      cyc++;
      hs  = e_valid && bus.m_ready;
      acc = bus.db_valid && loaded && !bus.q_load && (!e_valid || bus.m_ready);
      if (hs) log_q.push_back('{e_pos, e_eq, e_last, cyc});
      if (bus.q_load) begin
        loaded = 1; mq = bus.q_word; hist.delete(); k = 0; e_valid = 0;
      end else begin
        if (hs) e_valid = 0;
        if (acc) begin
          hist.push_back(bus.db_nt);
          if (hist.size() > W) void'(hist.pop_front());
          if (hist.size() == W) begin
            for (int i = 0; i < W; i++) e_eq[i] = (hist[i] == mq[2*i +: 2]);
            e_pos   = POS_W'(k - (W - 1));
            e_last  = bus.db_last;
            e_valid = 1;
          end
          k++;
          if (bus.db_last) begin hist.delete(); k = 0; end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("db_ready", bus.db_ready, exp_ready);
    chk("m_valid", bus.m_valid, e_valid);
    if (e_valid) begin
      chk("m_eq", bus.m_eq, e_eq);
      chk("m_pos", bus.m_pos, e_pos);
      chk("m_last", bus.m_last, e_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic send(logic [1:0] nt, logic last);
    bit a = 0;
    int budget = 0;
    bus.db_valid = 1; bus.db_nt = nt; bus.db_last = last;
    do begin
      @(negedge clk);
      a = exp_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!a && budget < 50);
    if (!a) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: nucleotide not accepted within %0d cycles", budget);
    end
  endtask

  task automatic send_str(string s, bit last_at_end);
    for (int i = 0; i < s.len(); i++)
      send(code(s[i]), last_at_end && (i == s.len() - 1));
    bus.db_valid = 0; bus.db_last = 0;
  endtask

  task automatic load(string s);
    logic [2*W-1:0] qw = '0;
    for (int i = 0; i < W; i++) qw[2*i +: 2] = code(s[i]);
    bus.q_load = 1; bus.q_word = qw;
    tick();
    bus.q_load = 0;
  endtask

  task automatic chk_log(string tag, int n, logic [W-1:0] eqs[], int unsigned last_idx);
    chk({tag, "_count"}, log_q.size(), n);
    for (int i = 0; i < log_q.size() && i < n; i++) begin
      chk({tag, "_pos"}, log_q[i].pos, i);
      chk({tag, "_eq"}, log_q[i].eq, eqs[i]);
      chk({tag, "_last"}, log_q[i].last, (i == last_idx));
      chk({tag, "_cyc"}, log_q[i].cyc - log_q[0].cyc, i);
    end
  endtask

  initial begin
    logic [W-1:0] eqs[];
    bus.q_load = 0; bus.q_word = '0; bus.db_valid = 0; bus.db_nt = 0;
    bus.db_last = 0; bus.m_ready = 1;
    rst = 1;
    #3;
    chk("rst_db_ready", bus.db_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_eq", bus.m_eq, 0);
    chk("rst_m_pos", bus.m_pos, 0);
    chk("rst_m_last", bus.m_last, 0);
    @(posedge clk); #1;
    rst = 0;

    // No query loaded: stream is refused.
    bus.db_valid = 1; bus.db_nt = 2'd1;
    repeat (5) begin
      tick();
      chk("idle_db_ready", bus.db_ready, 0);
      chk("idle_m_valid", bus.m_valid, 0);
    end
    bus.db_valid = 0;

    // Exact 11-nt match.
    load("ACGTACGTACG");
    log_q.delete();
    send_str("ACGTACGTACG", 1);
    idle(3);
    eqs = '{11'h7FF};
    chk_log("t2", 1, eqs, 0);

    // 13 nt back-to-back: three consecutive windows.
    log_q.delete();
    send_str("ACGTACGTACGTA", 1);
    idle(3);
    eqs = '{11'h7FF, 11'h000, 11'h000};
    chk_log("t3", 3, eqs, 2);

    // Backpressure on the first window of a 14-nt sequence.
    log_q.delete();
    fork
      send_str("ACGTACGTACGTAC", 1);
      begin
        int b = 0;
        logic [POS_W-1:0] sp; logic [W-1:0] se; bit sl;
        while (!e_valid && b < 100) begin tick(); b++; end
        bus.m_ready = 0;
        sp = e_pos; se = e_eq; sl = e_last;
        repeat (3) begin
          tick();
          chk("bp_db_ready", bus.db_ready, 0);
          chk("bp_m_valid", bus.m_valid, 1);
          chk("bp_m_pos", bus.m_pos, sp);
          chk("bp_m_eq", bus.m_eq, se);
          chk("bp_m_last", bus.m_last, sl);
        end
        bus.m_ready = 1;
      end
    join
    idle(3);
    chk("t4_count", log_q.size(), 4);
    for (int i = 0; i < log_q.size() && i < 4; i++) begin
      chk("t4_pos", log_q[i].pos, i);
      chk("t4_eq", log_q[i].eq, (i == 0) ? 11'h7FF : 11'h000);
      chk("t4_last", log_q[i].last, (i == 3));
    end

    // Short sequence produces nothing; the next starts at position 0.
    log_q.delete();
    send_str("ACGTA", 1);
    send_str("ACGTACGTACG", 1);
    idle(3);
    eqs = '{11'h7FF};
    chk_log("t5", 1, eqs, 0);

    // q_load while a window is stalled drops it and restarts the sequence.
    log_q.delete();
    bus.m_ready = 0;
    send_str("ACGTACGTACG", 0);
    chk("t6_valid_held", bus.m_valid, 1);
    load("TTTTTTTTTTT");
    chk("t6_valid_after_qload", bus.m_valid, 0);
    bus.m_ready = 1;
    send_str("TTTTTTTTTTT", 1);
    idle(3);
    eqs = '{11'h7FF};
    chk_log("t6", 1, eqs, 0);

    // Asynchronous reset mid-stream with a pending window.
    bus.m_ready = 0;
    send_str("ACGTACGTACG", 0);
    chk("t7_pending_valid", bus.m_valid, 1);
    chk("t7_pending_eq", bus.m_eq, 11'h088);
    #2;
    rst = 1;
    #1;
    chk("t7_rst_db_ready", bus.db_ready, 0);
    chk("t7_rst_m_valid", bus.m_valid, 0);
    chk("t7_rst_m_eq", bus.m_eq, 0);
    chk("t7_rst_m_pos", bus.m_pos, 0);
    chk("t7_rst_m_last", bus.m_last, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.m_ready = 1;
    idle(3);
    chk("t7_post_db_ready", bus.db_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
